// File: rtl/feature_scan_pkg.sv
// Shared types and default geometry for the grid feature scanner and matcher.
package feature_scan_pkg;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_e;

  localparam int DIST_W = 8;

  localparam int DEF_GRID_COLS = 3;
  localparam int DEF_GRID_ROWS = 3;
  localparam int DEF_CELL_W    = 18;
  localparam int DEF_CELL_H    = 25;
  localparam int DEF_CNT_W     = 12;
  localparam int DEF_NUM_TEMPL = 10;
  localparam int DEF_POS_W     = 12;

  function automatic int code_width(input int rows, input int cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/feature_popcount.sv
// Combinational population count of an N-bit vector, zero latency.
module feature_popcount
  import feature_scan_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N-1:0]      bits_i,
  output logic [DIST_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + DIST_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/feature_grid_matcher.sv
// Counts foreground pixels per box cell each frame, then matches the latched cell code
// against NUM_TEMPL templates by Hamming distance; result NUM_TEMPL+1 cycles after frame end.
module feature_grid_matcher
  import feature_scan_pkg::*;
#(
  parameter int GRID_COLS = DEF_GRID_COLS,
  parameter int GRID_ROWS = DEF_GRID_ROWS,
  parameter int CELL_W    = DEF_CELL_W,
  parameter int CELL_H    = DEF_CELL_H,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int NUM_TEMPL = DEF_NUM_TEMPL,
  parameter int POS_W     = DEF_POS_W
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  i_vs,
  input  logic                                                  i_de,
  input  logic [POS_W-1:0]                                      i_x,
  input  logic [POS_W-1:0]                                      i_y,
  input  logic                                                  i_th,
  input  logic [POS_W-1:0]                                      char_up,
  input  logic [POS_W-1:0]                                      char_down,
  input  logic [POS_W-1:0]                                      char_left,
  input  logic [POS_W-1:0]                                      char_right,
  input  logic [CNT_W-1:0]                                      cell_th,
  input  logic [DIST_W-1:0]                                     max_dist,
  input  logic [NUM_TEMPL*code_width(GRID_ROWS,GRID_COLS)-1:0]  templates,
  output logic [code_width(GRID_ROWS,GRID_COLS)-1:0]            feature_code,
  output logic [$clog2(NUM_TEMPL)-1:0]                          match_idx,
  output logic [DIST_W-1:0]                                     match_dist,
  output logic                                                  match_hit,
  output logic                                                  match_valid,
  output logic                                                  busy
);

  localparam int N     = code_width(GRID_ROWS, GRID_COLS);
  localparam int IDX_W = $clog2(NUM_TEMPL);
  localparam int XW    = POS_W + 1;
  localparam logic [IDX_W-1:0] LAST_T  = IDX_W'(NUM_TEMPL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Cell boundaries are evaluated one bit wider so left+offset cannot wrap.
  logic [GRID_COLS-1:0] col_hit;
  logic [GRID_ROWS-1:0] row_hit;
  logic                 in_box;
  logic                 pix_en;
  logic [N-1:0]         cell_inc;

  for (genvar c = 0; c < GRID_COLS; c++) begin : g_col
    logic [XW-1:0] lo;
    logic [XW-1:0] hi;
    assign lo = {1'b0, char_left} + XW'(c * CELL_W);
    assign hi = (c == GRID_COLS - 1) ? {1'b0, char_right}
                                     : {1'b0, char_left} + XW'((c + 1) * CELL_W - 1);
    assign col_hit[c] = ({1'b0, i_x} >= lo) && ({1'b0, i_x} <= hi);
  end

  for (genvar r = 0; r < GRID_ROWS; r++) begin : g_row
    logic [XW-1:0] lo;
    logic [XW-1:0] hi;
    assign lo = {1'b0, char_up} + XW'(r * CELL_H);
    assign hi = (r == GRID_ROWS - 1) ? {1'b0, char_down}
                                     : {1'b0, char_up} + XW'((r + 1) * CELL_H - 1);
    assign row_hit[r] = ({1'b0, i_y} >= lo) && ({1'b0, i_y} <= hi);
  end

  assign in_box = (i_x >= char_left) && (i_x <= char_right) &&
                  (i_y >= char_up)   && (i_y <= char_down);
  assign pix_en = i_vs && i_de && i_th && in_box;

  for (genvar r = 0; r < GRID_ROWS; r++) begin : g_cr
    for (genvar c = 0; c < GRID_COLS; c++) begin : g_cc
      assign cell_inc[r*GRID_COLS + c] = pix_en && row_hit[r] && col_hit[c];
    end
  end

  logic [CNT_W-1:0] cnt_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) cnt_q[k] <= '0;
    end else if (!i_vs) begin
      for (int k = 0; k < N; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (cell_inc[k] && (cnt_q[k] != CNT_MAX)) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  logic         vs_q;
  logic         frame_end;
  logic [N-1:0] code_d, code_q;

  assign frame_end = vs_q && !i_vs;

  always_comb begin
    code_d = code_q;
    if (frame_end) begin
      for (int k = 0; k < N; k++) code_d[k] = (cnt_q[k] >= cell_th);
    end
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    tidx_q, tidx_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic [DIST_W-1:0]   best_dist_q, best_dist_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIST_W-1:0]   dist_q, dist_d;
  logic                hit_q, hit_d;
  logic [N-1:0]        cur_templ;
  logic [DIST_W-1:0]   cur_dist;

  assign cur_templ = templates[tidx_q*N +: N];

  feature_popcount #(.N(N)) u_popcount (
    .bits_i  (code_q ^ cur_templ),
    .count_o (cur_dist)
  );

  // A new frame end always restarts the compare, even mid-compare.
  always_comb begin
    state_d     = state_q;
    tidx_d      = tidx_q;
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    idx_d       = idx_q;
    dist_d      = dist_q;
    hit_d       = hit_q;
    if (frame_end) begin
      state_d     = CMP;
      tidx_d      = '0;
      best_idx_d  = '0;
      best_dist_d = '1;
    end else begin
      case (state_q)
        CMP: begin
          if (cur_dist < best_dist_q) begin
            best_dist_d = cur_dist;
            best_idx_d  = tidx_q;
          end
          if (tidx_q == LAST_T) begin
            state_d = DONE;
            idx_d   = best_idx_d;
            dist_d  = best_dist_d;
            hit_d   = (best_dist_d <= max_dist);
          end else begin
            tidx_d = tidx_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      code_q      <= '0;
      state_q     <= IDLE;
      tidx_q      <= '0;
      best_idx_q  <= '0;
      best_dist_q <= '0;
      idx_q       <= '0;
      dist_q      <= '0;
      hit_q       <= 1'b0;
    end else begin
      vs_q        <= i_vs;
      code_q      <= code_d;
      state_q     <= state_d;
      tidx_q      <= tidx_d;
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
      idx_q       <= idx_d;
      dist_q      <= dist_d;
      hit_q       <= hit_d;
    end
  end

  assign feature_code = code_q;
  assign match_idx    = idx_q;
  assign match_dist   = dist_q;
  assign match_hit    = hit_q;
  assign match_valid  = (state_q == DONE);
  assign busy         = (state_q == CMP);

endmodule

// File: tb/tb_feature_grid_matcher.sv
// Directed bench for feature_grid_matcher: table of per-cell pixel counts with expected
// match results, plus hand sequences for cell edges, saturation, abort and reset.
module tb_feature_grid_matcher;

  localparam int N  = 9;
  localparam int NT = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_vs, i_de, i_th;
  logic [11:0]      i_x, i_y;
  logic [11:0]      char_up, char_down, char_left, char_right;
  logic [11:0]      cell_th;
  logic [7:0]       max_dist;
  logic [NT*N-1:0]  templates;
  logic [N-1:0]     feature_code;
  logic [3:0]       match_idx;
  logic [7:0]       match_dist;
  logic             match_hit, match_valid, busy;

  int total = 0;
  int bad   = 0;
  int vld_cnt = 0;

  feature_grid_matcher dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_vs         (i_vs),
    .i_de         (i_de),
    .i_x          (i_x),
    .i_y          (i_y),
    .i_th         (i_th),
    .char_up      (char_up),
    .char_down    (char_down),
    .char_left    (char_left),
    .char_right   (char_right),
    .cell_th      (cell_th),
    .max_dist     (max_dist),
    .templates    (templates),
    .feature_code (feature_code),
    .match_idx    (match_idx),
    .match_dist   (match_dist),
    .match_hit    (match_hit),
    .match_valid  (match_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (match_valid === 1'b1) vld_cnt++;

  typedef struct {
    int         cnt [9];
    int         th;
    int         maxd;
    logic [8:0] tmpl [10];
    logic [8:0] e_code;
    int         e_idx;
    int         e_dist;
    int         e_hit;
  } vec_t;

  vec_t vec [5];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] cx(input int k);
    return 12'(100 + (k % 3) * 18 + 5);
  endfunction

  function automatic logic [11:0] cy(input int k);
    return 12'(50 + (k / 3) * 25 + 5);
  endfunction

  task automatic pix(input logic [11:0] x, input logic [11:0] y, input logic th);
    @(posedge clk); #1;
    i_de = 1'b1; i_x = x; i_y = y; i_th = th;
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    i_vs = 1'b1; i_de = 1'b0; i_th = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic fall();
    @(posedge clk); #1;
    i_de = 1'b0; i_th = 1'b0; i_vs = 1'b0;
  endtask

  task automatic set_templ_all(input logic [8:0] v);
    for (int t = 0; t < NT; t++) templates[t*N +: N] = v;
  endtask

  // Called right after the falling i_vs is driven; cycle 0 is the frame-end cycle.
  task automatic await_result(input string nm, input int ec, input int ei,
                              input int ed, input int eh);
    int lat;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 1) check({nm, "_busy"}, int'(busy), 1);
      if (match_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({nm, "_latency"}, lat, NT + 1);
    check({nm, "_code"}, int'(feature_code), ec);
    check({nm, "_idx"},  int'(match_idx), ei);
    check({nm, "_dist"}, int'(match_dist), ed);
    check({nm, "_hit"},  int'(match_hit), eh);
    @(negedge clk);
    check({nm, "_pulse_len"}, int'(match_valid), 0);
    check({nm, "_idle"}, int'(busy), 0);
  endtask

  task automatic run_vec(input int v);
    start_frame();
    for (int k = 0; k < 9; k++) begin
      for (int n = 0; n < 3; n++) pix(cx(k), cy(k), 1'b0);
      for (int n = 0; n < vec[v].cnt[k]; n++) pix(cx(k), cy(k), 1'b1);
    end
    cell_th  = 12'(vec[v].th);
    max_dist = 8'(vec[v].maxd);
    for (int t = 0; t < NT; t++) templates[t*N +: N] = vec[v].tmpl[t];
    fall();
    await_result($sformatf("vec%0d", v), int'(vec[v].e_code), vec[v].e_idx,
                 vec[v].e_dist, vec[v].e_hit);
  endtask

  initial begin
    int base;

    vec[0].cnt = '{100, 100, 100, 100, 0, 100, 100, 100, 100};
    vec[0].th = 60; vec[0].maxd = 2;
    vec[0].tmpl = '{default: 9'h000}; vec[0].tmpl[0] = 9'h1EF;
    vec[0].e_code = 9'h1EF; vec[0].e_idx = 0; vec[0].e_dist = 0; vec[0].e_hit = 1;

    vec[1].cnt = '{70, 10, 10, 10, 10, 10, 10, 10, 70};
    vec[1].th = 60; vec[1].maxd = 0;
    vec[1].tmpl = '{default: 9'h0FE}; vec[1].tmpl[3] = 9'h100; vec[1].tmpl[7] = 9'h001;
    vec[1].e_code = 9'h101; vec[1].e_idx = 3; vec[1].e_dist = 1; vec[1].e_hit = 0;

    vec[2] = vec[1];
    vec[2].maxd = 1; vec[2].e_hit = 1;

    vec[3].cnt = '{0, 0, 5, 0, 0, 0, 4, 0, 0};
    vec[3].th = 5; vec[3].maxd = 0;
    vec[3].tmpl = '{default: 9'h1FF}; vec[3].tmpl[9] = 9'h004;
    vec[3].e_code = 9'h004; vec[3].e_idx = 9; vec[3].e_dist = 0; vec[3].e_hit = 1;

    vec[4].cnt = '{default: 0};
    vec[4].th = 0; vec[4].maxd = 8;
    vec[4].tmpl = '{default: 9'h000};
    vec[4].e_code = 9'h1FF; vec[4].e_idx = 0; vec[4].e_dist = 9; vec[4].e_hit = 0;

    rst_n = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_th = 1'b0; i_x = '0; i_y = '0;
    char_left = 12'd100; char_right = 12'd153; char_up = 12'd50; char_down = 12'd124;
    cell_th = 12'd60; max_dist = 8'd0; templates = '0;

    repeat (2) @(negedge clk);
    check("rst_code",  int'(feature_code), 0);
    check("rst_idx",   int'(match_idx), 0);
    check("rst_dist",  int'(match_dist), 0);
    check("rst_hit",   int'(match_hit), 0);
    check("rst_valid", int'(match_valid), 0);
    check("rst_busy",  int'(busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) run_vec(v);

    // Cell edges: column/row starts, last-cell inclusive corner, and just-outside pixels.
    start_frame();
    pix(12'd118, 12'd75, 1'b1);
    pix(12'd117, 12'd99, 1'b1);
    pix(12'd153, 12'd124, 1'b1);
    pix(12'd154, 12'd60, 1'b1);
    pix(12'd99, 12'd60, 1'b1);
    pix(12'd120, 12'd49, 1'b1);
    pix(12'd120, 12'd125, 1'b1);
    pix(12'd105, 12'd55, 1'b0);
    cell_th = 12'd1; max_dist = 8'd3; set_templ_all(9'h000);
    fall();
    await_result("edges", 9'h118, 0, 3, 1);

    // 5000 hits in one cell: a wrapping counter would read 904 and miss the threshold.
    start_frame();
    for (int n = 0; n < 5000; n++) pix(cx(0), cy(0), 1'b1);
    cell_th = 12'd4095; max_dist = 8'd1; set_templ_all(9'h000);
    fall();
    await_result("sat", 9'h001, 0, 1, 1);

    // Second frame ends while the first is still being compared.
    cell_th = 12'd1; max_dist = 8'd0;
    set_templ_all(9'h0FE); templates[0 +: N] = 9'h001; templates[5*N +: N] = 9'h100;
    start_frame();
    pix(cx(0), cy(0), 1'b1);
    base = vld_cnt;
    fall();
    @(posedge clk); #1; i_vs = 1'b1;
    pix(cx(8), cy(8), 1'b1);
    @(posedge clk); #1; i_de = 1'b0; i_th = 1'b0;
    fall();
    check("abort_no_early_pulse", vld_cnt - base, 0);
    await_result("abort", 9'h100, 5, 0, 1);
    repeat (15) @(negedge clk);
    check("abort_single_pulse", vld_cnt - base, 1);

    // Reset mid-frame clears all results, then a full frame matches normally.
    start_frame();
    for (int n = 0; n < 4; n++) pix(cx(4), cy(4), 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_th = 1'b0;
    @(negedge clk);
    check("mrst_code",  int'(feature_code), 0);
    check("mrst_idx",   int'(match_idx), 0);
    check("mrst_hit",   int'(match_hit), 0);
    check("mrst_valid", int'(match_valid), 0);
    check("mrst_busy",  int'(busy), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
